// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame buffer arbiter.
// Provides geometry constants, the grant type and the write-entry bundle.
package vga_pkg;

    localparam int DATA_W = 12;
    localparam int ROW_W  = 8;
    localparam int COL_W  = 9;
    localparam int ROWS   = 240;
    localparam int COLS   = 320;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        FORCE
    } grant_t;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] pixel;
    } wr_entry_t;

    function automatic logic in_range(
        input logic [ROW_W-1:0] r,
        input logic [COL_W-1:0] c
    );
        return (int'(r) < ROWS) && (int'(c) < COLS);
    endfunction

endpackage

// File: rtl/vga_buffer_arbiter_fifo.sv
// pixel_write_fifo: synchronous FIFO holding pending pixel writes.
// Ports: push/din in, pop/dout (head, registered storage), full/empty/level.
module pixel_write_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wr_entry_t              din,
    input  logic                   pop,
    output wr_entry_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    wr_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage needs no reset; level/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/vga_buffer_arbiter.sv
// Arbitrates the single-port frame buffer between VGA reads and queued writes.
// Ports: writer (wr_*), VGA reader (rd_*), RAM port (ram_*), oob_err, fifo_level.
module vga_buffer_arbiter
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ROW_W-1:0]            wr_row,
    input  logic [COL_W-1:0]            wr_col,
    input  logic [DATA_W-1:0]           wr_pixel,
    input  logic                        rd_req,
    input  logic [ROW_W-1:0]            rd_row,
    input  logic [COL_W-1:0]            rd_col,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_pixel,
    output logic                        rd_dropped,
    output logic [ROW_W-1:0]            ram_row,
    output logic [COL_W-1:0]            ram_col,
    output logic                        ram_we,
    output logic [DATA_W-1:0]           ram_wdata,
    input  logic [DATA_W-1:0]           ram_rdata,
    output logic                        oob_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    grant_t            grant;
    wr_entry_t         head;
    wr_entry_t         entry;
    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic              starved;
    logic [SW-1:0]     starve;
    logic [DATA_W-1:0] rd_hold;

    // Full comes from the level register, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign wr_ready = ~full;
    assign accept   = wr_valid & wr_ready;
    assign push     = accept & in_range(wr_row, wr_col);
    assign entry    = '{row: wr_row, col: wr_col, pixel: wr_pixel};

    pixel_write_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (entry),
        .pop  (pop),
        .dout (head),
        .full (full),
        .empty(empty),
        .level(fifo_level)
    );

    assign starved = full && (starve == SW'(STARVE_LIMIT));

    always_comb begin
        grant = IDLE;
        if (rst) begin
            grant = IDLE;
        end else if (rd_req) begin
            grant = starved ? FORCE : READ;
        end else if (!empty) begin
            grant = WRITE;
        end
    end

    assign pop = (grant == WRITE) || (grant == FORCE);

    always_comb begin
        ram_row   = '0;
        ram_col   = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        unique case (grant)
            READ: begin
                ram_row = rd_row;
                ram_col = rd_col;
            end
            WRITE, FORCE: begin
                ram_row   = head.row;
                ram_col   = head.col;
                ram_we    = 1'b1;
                ram_wdata = head.pixel;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
        end else if (pop || !full) begin
            starve <= '0;
        end else if (grant == READ && !starved) begin
            starve <= starve + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            rd_dropped <= 1'b0;
            rd_hold    <= '0;
            oob_err    <= 1'b0;
        end else begin
            rd_valid   <= (grant == READ);
            rd_dropped <= (grant == FORCE);
            if (rd_valid) rd_hold <= ram_rdata;
            if (accept && !push) oob_err <= 1'b1;
        end
    end

    // Returned data is the RAM's registered output in the valid
    // cycle; otherwise the last returned pixel is held.
    assign rd_pixel = rd_valid ? ram_rdata : rd_hold;

endmodule

// File: tb/tb_vga_buffer_arbiter.sv
// Self-checking bench for vga_buffer_arbiter.
// Queue-based model checked every cycle plus directed literal checks.
module tb_vga_buffer_arbiter;
    import vga_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_row = '0;
    logic [8:0]  wr_col = '0;
    logic [11:0] wr_pixel = '0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_row = '0;
    logic [8:0]  rd_col = '0;
    logic        rd_valid;
    logic [11:0] rd_pixel;
    logic        rd_dropped;
    logic [7:0]  ram_row;
    logic [8:0]  ram_col;
    logic        ram_we;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata = '0;
    logic        oob_err;
    logic [2:0]  fifo_level;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_buffer_arbiter #(
        .FIFO_DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_pixel(wr_pixel),
        .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
        .rd_valid(rd_valid), .rd_pixel(rd_pixel), .rd_dropped(rd_dropped),
        .ram_row(ram_row), .ram_col(ram_col), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .oob_err(oob_err), .fifo_level(fifo_level)
    );

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [11:0] ram_init(input int k);
        return 12'(k * 7 + 3);
    endfunction

    // Frame buffer RAM: registered read, write on ram_we.
    logic [11:0] mem [int];
    always @(posedge clk) begin
        int k;
        k = int'({ram_row, ram_col});
        if (ram_we) mem[k] = ram_wdata;
        else ram_rdata <= mem.exists(k) ? mem[k] : ram_init(k);
    end

    // Behavioural model: pending writes as a queue, image as an array.
    typedef struct {
        int row;
        int col;
        int pix;
    } ent_t;

    ent_t        q[$];
    logic [11:0] mmem [int];
    int          starve = 0;
    bit          prv_rd = 0;
    bit          prv_force = 0;
    bit          m_oob = 0;
    logic [11:0] pend = '0;
    logic [11:0] held = '0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_wr_ready", 32'(wr_ready), 1);
            chk("rst_level", 32'(fifo_level), 0);
            chk("rst_rd_valid", 32'(rd_valid), 0);
            chk("rst_rd_dropped", 32'(rd_dropped), 0);
            chk("rst_ram_we", 32'(ram_we), 0);
            chk("rst_ram_addr", 32'({ram_row, ram_col}), 0);
            chk("rst_ram_wdata", 32'(ram_wdata), 0);
            chk("rst_oob", 32'(oob_err), 0);
            q.delete();
            starve = 0;
            prv_rd = 0;
            prv_force = 0;
            m_oob = 0;
            pend = '0;
            held = '0;
        end else begin
            bit full, pop, is_rd, is_force;
            int er, ec, ew, ed, k;
            ent_t e;
            full = (q.size() == DEPTH);
            is_rd = rd_req && !(full && starve == LIMIT);
            is_force = rd_req && !is_rd;
            pop = is_force || (!rd_req && q.size() > 0);
            er = 0; ec = 0; ew = 0; ed = 0;
            if (is_rd) begin
                er = int'(rd_row);
                ec = int'(rd_col);
            end else if (pop) begin
                er = q[0].row;
                ec = q[0].col;
                ew = 1;
                ed = q[0].pix;
            end
            chk("wr_ready", 32'(wr_ready), 32'(!full));
            chk("fifo_level", 32'(fifo_level), q.size());
            chk("ram_we", 32'(ram_we), ew);
            chk("ram_row", 32'(ram_row), er);
            chk("ram_col", 32'(ram_col), ec);
            chk("ram_wdata", 32'(ram_wdata), ed);
            chk("rd_valid", 32'(rd_valid), 32'(prv_rd));
            chk("rd_dropped", 32'(rd_dropped), 32'(prv_force));
            chk("rd_pixel", 32'(rd_pixel), prv_rd ? pend : held);
            chk("oob_err", 32'(oob_err), 32'(m_oob));
            if (pop) begin
                e = q.pop_front();
                mmem[(e.row << 9) | e.col] = 12'(e.pix);
            end
            if (is_rd && full && starve < LIMIT) starve++;
            if (pop || !full) starve = 0;
            if (wr_valid && !full) begin
                if (wr_row >= 8'(ROWS) || wr_col >= 9'(COLS)) m_oob = 1;
                else q.push_back('{int'(wr_row), int'(wr_col),
                                   int'(wr_pixel)});
            end
            if (prv_rd) held = pend;
            prv_rd = is_rd;
            prv_force = is_force;
            if (is_rd) begin
                k = int'({rd_row, rd_col});
                pend = mmem.exists(k) ? mmem[k] : ram_init(k);
            end
        end
    end

    task automatic step(input bit v, input int r, input int c, input int p,
                        input bit rq, input int rr, input int rc);
        @(posedge clk);
        #1;
        wr_valid = v;
        wr_row = 8'(r);
        wr_col = 9'(c);
        wr_pixel = 12'(p);
        rd_req = rq;
        rd_row = 8'(rr);
        rd_col = 9'(rc);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int first_we;
        int drops;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t1_wr_ready", 32'(wr_ready), 1);
        chk("t1_level", 32'(fifo_level), 0);
        chk("t1_rd_valid", 32'(rd_valid), 0);

        step(1, 5, 3, 12'hBBB, 0, 0, 0);
        idle();
        @(negedge clk);
        chk("t2_we", 32'(ram_we), 1);
        chk("t2_row", 32'(ram_row), 5);
        chk("t2_col", 32'(ram_col), 3);
        chk("t2_wdata", 32'(ram_wdata), 12'hBBB);
        idle();
        @(negedge clk);
        chk("t2_level", 32'(fifo_level), 0);
        chk("t2_we_off", 32'(ram_we), 0);

        step(1, 2, 7, 12'hCCC, 1, 5, 3);
        step(0, 0, 0, 0, 1, 5, 3);
        @(negedge clk);
        chk("t3_no_we", 32'(ram_we), 0);
        chk("t3_rd_valid", 32'(rd_valid), 1);
        chk("t3_rd_pixel", 32'(rd_pixel), 12'hBBB);
        step(0, 0, 0, 0, 1, 5, 3);
        @(negedge clk);
        chk("t3_no_we2", 32'(ram_we), 0);
        idle();
        @(negedge clk);
        chk("t3_we", 32'(ram_we), 1);
        chk("t3_row", 32'(ram_row), 2);
        chk("t3_col", 32'(ram_col), 7);
        chk("t3_wdata", 32'(ram_wdata), 12'hCCC);
        chk("t3_rd_valid2", 32'(rd_valid), 1);

        for (int i = 0; i < 4; i++)
            step(1, 20 + i, 30 + i, 12'h100 + i, 1, 10, 10);
        first_we = -1;
        drops = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 9) step(1, 7, 7, 12'h777, 1, 10, 10);
            else step(0, 0, 0, 0, 1, 10, 10);
            @(negedge clk);
            if (ram_we && first_we < 0) first_we = i;
            if (rd_dropped) drops++;
        end
        chk("t4_first_force", 32'(first_we), 8);
        chk("t4_drops", 32'(drops), 2);
        repeat (4) idle();
        @(negedge clk);
        chk("t4_drained", 32'(fifo_level), 0);

        step(1, 240, 0, 12'hAAA, 0, 0, 0);
        step(1, 0, 320, 12'hAAA, 0, 0, 0);
        idle();
        @(negedge clk);
        chk("t5_oob", 32'(oob_err), 1);
        chk("t5_level", 32'(fifo_level), 0);
        chk("t5_no_we", 32'(ram_we), 0);
        idle();
        @(negedge clk);
        chk("t5_oob_sticky", 32'(oob_err), 1);

        for (int i = 0; i < 3; i++)
            step(1, 40 + i, 50 + i, 12'h200 + i, 1, 1, 1);
        step(0, 0, 0, 0, 1, 1, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd_req = 1'b0;
        @(negedge clk);
        chk("t6_level", 32'(fifo_level), 0);
        chk("t6_rd_valid", 32'(rd_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) idle();
        @(negedge clk);
        chk("t6_no_we", 32'(ram_we), 0);
        chk("t6_oob_clr", 32'(oob_err), 0);
        chk("t6_wr_ready", 32'(wr_ready), 1);

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
